// File: rtl/bus_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS layout, shifter states and the divisor helper.
package bus_uart_tx_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned BIT_W  = 3;

  localparam logic [ADDR_W-1:0] REG_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] REG_STATUS  = 2'd1;
  localparam logic [ADDR_W-1:0] REG_DIVISOR = 2'd2;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_EMPTY     = 2;
  localparam int unsigned STAT_OVERFLOW  = 3;
  localparam int unsigned STAT_LEVEL_LSB = 8;
  localparam int unsigned STAT_LEVEL_W   = 8;

  localparam logic [DIV_W-1:0] DEFAULT_DIVISOR_VAL = 16'd434;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // A divisor of zero behaves as one clock per bit.
  function automatic logic [DIV_W-1:0] eff_divisor(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 serialiser: takes a byte via load_valid/load_ready and shifts it out
// LSB first, each bit lasting max(divisor,1) clocks.
module uart_tx_shifter
  import bus_uart_tx_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [BYTE_W-1:0] load_data,
  input  logic [DIV_W-1:0]  divisor,
  output logic              tx,
  output logic              busy
);

  tx_state_e         state_q;
  logic [BYTE_W-1:0] shift_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DIV_W-1:0]  cnt_q;
  logic              tx_q;
  logic [DIV_W-1:0]  reload;
  logic              bit_done;

  // Divisor is sampled only when a new bit starts.
  assign reload     = eff_divisor(divisor) - DIV_W'(1);
  assign bit_done   = (cnt_q == '0);
  assign load_ready = (state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_done);
  assign busy       = (state_q != ST_IDLE);
  assign tx         = tx_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_valid) begin
            state_q <= ST_START;
            tx_q    <= 1'b0;
            shift_q <= load_data;
            cnt_q   <= reload;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
            cnt_q   <= reload;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            cnt_q <= reload;
            if (bit_q == BIT_W'(7)) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + BIT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            // Back-to-back frames: go straight to the next start bit.
            if (load_valid) begin
              state_q <= ST_START;
              tx_q    <= 1'b0;
              shift_q <= load_data;
              cnt_q   <= reload;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Bus responder for the UART transmitter: register decode, TX FIFO,
// STATUS/overflow tracking and the divisor register.
module bus_uart_tx
  import bus_uart_tx_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH      = 8,
  parameter logic [DIV_W-1:0]  DEFAULT_DIVISOR = DEFAULT_DIVISOR_VAL
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [STRB_W-1:0] data_strobes,
  input  logic              read,
  input  logic              write,
  output logic              tx,
  output logic              irq
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DIV_W-1:0]  divisor_q, divisor_d;

  logic              wr_cyc, rd_cyc;
  logic              push_req, push, drop, pop;
  logic              full, empty;
  logic              status_rd, div_wr;
  logic              load_valid, load_ready, busy;
  logic [DATA_W-1:0] status_word;
  logic              unused_bus;

  // A cycle with both read and write asserted is a write only.
  assign wr_cyc    = cs & write;
  assign rd_cyc    = cs & read & ~write;

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push_req  = wr_cyc & (address == REG_DATA) & data_strobes[0];
  assign push      = push_req & ~full;
  assign drop      = push_req & full;
  assign load_valid = ~empty;
  assign pop       = load_valid & load_ready;
  assign status_rd = rd_cyc & (address == REG_STATUS);
  assign div_wr    = wr_cyc & (address == REG_DIVISOR);
  assign irq       = empty & ~busy;

  assign unused_bus = ^{data_in[DATA_W-1:2*BYTE_W], data_strobes[STRB_W-1:2]};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    divisor_d  = divisor_q;
    // A dropped push on the same edge as a STATUS read keeps the flag set.
    overflow_d = (overflow_q & ~status_rd) | drop;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (div_wr) begin
      if (data_strobes[0]) divisor_d[BYTE_W-1:0]      = data_in[BYTE_W-1:0];
      if (data_strobes[1]) divisor_d[DIV_W-1:BYTE_W]  = data_in[DIV_W-1:BYTE_W];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      divisor_q  <= DEFAULT_DIVISOR;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      divisor_q  <= divisor_d;
    end
  end

  // FIFO storage needs no reset; the pointers define validity.
  always_ff @(posedge clock) begin
    if (reset && push) mem_q[wr_ptr_q] <= data_in[BYTE_W-1:0];
  end

  always_comb begin
    status_word                = '0;
    status_word[STAT_BUSY]     = busy;
    status_word[STAT_FULL]     = full;
    status_word[STAT_EMPTY]    = empty;
    status_word[STAT_OVERFLOW] = overflow_q;
    status_word[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(count_q);
  end

  always_comb begin
    data_out = '0;
    if (rd_cyc) begin
      case (address)
        REG_STATUS:  data_out = status_word;
        REG_DIVISOR: data_out = DATA_W'(divisor_q);
        default:     data_out = '0;
      endcase
    end
  end

  uart_tx_shifter u_shifter (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (mem_q[rd_ptr_q]),
    .divisor    (divisor_q),
    .tx         (tx),
    .busy       (busy)
  );

endmodule
